// File: rtl/mib_pkg.sv
// Shared MIB bus widths and the slave register-file state encoding.
package mib_pkg;

    localparam int unsigned MIB_AD_W   = 16;
    localparam int unsigned MIB_ADDR_W = 32;
    localparam int unsigned MIB_DATA_W = 32;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_LO,
        DECODE,
        WR_HI,
        WR_LO,
        WR_ACK,
        TURN,
        RD_HI,
        RD_LO
    } mib_slv_state_t;

endpackage

// File: rtl/mib_slave_regfile.sv
// MIB bus slave: decodes master transactions into a bank of 32-bit registers.
// Optional MIB_SLAVE_WR_STROBE_EN adds a per-register one-clock write strobe.
module mib_slave_regfile
    import mib_pkg::*;
#(
    parameter logic [31:0]  P_BASE_ADDR          = 32'h0000_0000,
    parameter int unsigned  P_NUM_REGS           = 16,
    parameter int unsigned  P_RD_TURNAROUND_CLKS = 2,
    parameter logic [31:0]  P_RESET_VAL          = 32'h0
) (
    input  logic                               i_sysclk,
    input  logic                               i_srst,
    input  logic                               i_mib_start,
    input  logic                               i_mib_rd_wr_n,
    input  logic [MIB_AD_W-1:0]                i_mib_ad,
    output logic [MIB_AD_W-1:0]                o_mib_ad,
    output logic                               o_mib_ad_high_z,
    output logic                               o_mib_slave_ack,
    output logic [P_NUM_REGS*MIB_DATA_W-1:0]   o_regs
`ifdef MIB_SLAVE_WR_STROBE_EN
    ,
    output logic [P_NUM_REGS-1:0]              o_wr_strobe
`endif
);

    localparam int unsigned IDX_W  = $clog2(P_NUM_REGS);
    localparam int unsigned TURN_W = 8;

    mib_slv_state_t          state_q, state_c;
    logic [MIB_AD_W-1:0]     ad_q;
    logic                    rd_wr_n_q;
    logic [MIB_AD_W-1:0]     a_hi_q;
    logic [MIB_AD_W-1:0]     d_hi_q;
    logic [IDX_W-1:0]        idx_q;
    logic [TURN_W-1:0]       turn_cnt_q;
    logic [MIB_DATA_W-1:0]   rd_data_q;
    logic [MIB_DATA_W-1:0]   regs_q [P_NUM_REGS];
    logic                    hit_c;
    logic                    wr_en_c;

    // Address phase 2 is still on the registered bus input while in DECODE.
    assign hit_c   = (({a_hi_q, ad_q}) >> IDX_W) == (P_BASE_ADDR >> IDX_W);
    assign wr_en_c = (state_c == WR_ACK);

    // Next state; a new start always wins and restarts the address phase.
    always_comb begin
        state_c = state_q;
        unique case (state_q)
            IDLE:    state_c = IDLE;
            ADDR_LO: state_c = DECODE;
            DECODE:  state_c = !hit_c ? IDLE : (rd_wr_n_q ? TURN : WR_HI);
            WR_HI:   state_c = WR_LO;
            WR_LO:   state_c = WR_ACK;
            WR_ACK:  state_c = IDLE;
            TURN:    state_c = (turn_cnt_q == TURN_W'(P_RD_TURNAROUND_CLKS - 1)) ? RD_HI : TURN;
            RD_HI:   state_c = RD_LO;
            RD_LO:   state_c = IDLE;
            default: state_c = IDLE;
        endcase
        if (i_mib_start) begin
            state_c = ADDR_LO;
        end
    end

    // State register, input capture and transaction field latches.
    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            state_q    <= IDLE;
            ad_q       <= '0;
            rd_wr_n_q  <= 1'b0;
            a_hi_q     <= '0;
            d_hi_q     <= '0;
            idx_q      <= '0;
            turn_cnt_q <= '0;
        end else begin
            state_q <= state_c;
            ad_q    <= i_mib_ad;
            if (i_mib_start) begin
                rd_wr_n_q <= i_mib_rd_wr_n;
            end
            if (state_q == ADDR_LO) begin
                a_hi_q <= ad_q;
            end
            if (state_q == DECODE) begin
                idx_q <= ad_q[IDX_W-1:0];
            end
            if (state_q == WR_HI) begin
                d_hi_q <= ad_q;
            end
            turn_cnt_q <= (state_q == TURN) ? turn_cnt_q + TURN_W'(1) : '0;
        end
    end

    // Bus-side outputs follow the state being entered so they line up with it.
    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            o_mib_ad        <= '0;
            o_mib_ad_high_z <= 1'b1;
            o_mib_slave_ack <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            o_mib_slave_ack <= state_c inside {WR_ACK, RD_HI, RD_LO};
            o_mib_ad_high_z <= !(state_c inside {RD_HI, RD_LO});
            if (state_c == RD_HI) begin
                rd_data_q <= regs_q[idx_q];
                o_mib_ad  <= regs_q[idx_q][MIB_DATA_W-1:MIB_AD_W];
            end else if (state_c == RD_LO) begin
                o_mib_ad  <= rd_data_q[MIB_AD_W-1:0];
            end else begin
                o_mib_ad  <= '0;
            end
        end
    end

    // Register bank.
    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            for (int i = 0; i < int'(P_NUM_REGS); i++) begin
                regs_q[i] <= P_RESET_VAL;
            end
        end else if (wr_en_c) begin
            regs_q[idx_q] <= {d_hi_q, ad_q};
        end
    end

    for (genvar g = 0; g < int'(P_NUM_REGS); g++) begin : g_flat
        assign o_regs[g*MIB_DATA_W +: MIB_DATA_W] = regs_q[g];
    end

`ifdef MIB_SLAVE_WR_STROBE_EN
    // One-hot strobe coincides with the write ack.
    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            o_wr_strobe <= '0;
        end else begin
            o_wr_strobe <= wr_en_c ? (P_NUM_REGS'(1) << idx_q) : '0;
        end
    end
`else
    // Without the strobe a write is signalled to user logic only via o_regs.
`endif

endmodule

// File: tb/tb_mib_slave_regfile.sv
// Scoreboard bench for mib_slave_regfile: random MIB traffic against an array model.
module tb_mib_slave_regfile;

    localparam int unsigned N      = 16;
    localparam logic [31:0] BASE   = 32'h0000_0140;
    localparam int unsigned TURN   = 2;
    localparam logic [31:0] RSTV   = 32'h0BAD_F00D;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           rd_wr_n = 1'b0;
    logic [15:0]    ad_in = '0;
    logic [15:0]    ad_out;
    logic           high_z;
    logic           ack;
    logic [N*32-1:0] regs;
`ifdef MIB_SLAVE_WR_STROBE_EN
    logic [N-1:0]   wr_strobe;
`endif

    mib_slave_regfile #(
        .P_BASE_ADDR          (BASE),
        .P_NUM_REGS           (N),
        .P_RD_TURNAROUND_CLKS (TURN),
        .P_RESET_VAL          (RSTV)
    ) dut (
        .i_sysclk        (clk),
        .i_srst          (rst),
        .i_mib_start     (start),
        .i_mib_rd_wr_n   (rd_wr_n),
        .i_mib_ad        (ad_in),
        .o_mib_ad        (ad_out),
        .o_mib_ad_high_z (high_z),
        .o_mib_slave_ack (ack),
        .o_regs          (regs)
`ifdef MIB_SLAVE_WR_STROBE_EN
        ,
        .o_wr_strobe     (wr_strobe)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        hz;
        logic [15:0] ad;
        logic        chk_ad;
        int          widx;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] model [N];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit is_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + N);
    endfunction

    // Monitor: pops one expectation per ack cycle; bus must be released otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            logic [31:0] strobe_req;
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                check("missed_ack_cycle", 32'(cyc), 32'(expq[0].cyc));
                void'(expq.pop_front());
            end
            if (ack) begin
                if (expq.size() == 0 || expq[0].cyc != cyc) begin
                    check("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("ack_high_z", 32'(high_z), 32'(e.hz));
                    if (e.chk_ad) check("rd_data", 32'(ad_out), 32'(e.ad));
                    strobe_req = (e.widx >= 0) ? (32'd1 << e.widx) : 32'd0;
`ifdef MIB_SLAVE_WR_STROBE_EN
                    check("wr_strobe_ack", 32'(wr_strobe), strobe_req);
`else
                    if (e.widx >= 0) check("wr_reg_updated", regs[32*e.widx +: 32], model[e.widx]);
`endif
                end
            end else begin
                check("idle_high_z", 32'(high_z), 32'd1);
`ifdef MIB_SLAVE_WR_STROBE_EN
                check("wr_strobe_idle", 32'(wr_strobe), 32'd0);
`endif
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start   = 1'b0;
            rd_wr_n = 1'b0;
            ad_in   = 16'($urandom);
        end
    endtask

    // Drives ncyc bus cycles starting with the start pulse; returns start cycle k.
    task automatic issue(input bit is_rd, input logic [31:0] a, input logic [31:0] d,
                         input int ncyc, output int k);
        logic [15:0] w [4];
        w[0] = a[31:16];
        w[1] = a[15:0];
        w[2] = is_rd ? 16'($urandom) : d[31:16];
        w[3] = is_rd ? 16'($urandom) : d[15:0];
        @(posedge clk); #1;
        k       = cyc;
        start   = 1'b1;
        rd_wr_n = is_rd;
        ad_in   = w[0];
        for (int i = 1; i < ncyc; i++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            rd_wr_n = 1'b0;
            ad_in   = w[i];
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int next_at);
        int   k;
        exp_t e;
        issue(1'b0, a, d, 4, k);
        if (is_hit(a)) begin
            model[a - BASE] = d;
            e.cyc = k + 5; e.hz = 1'b1; e.ad = '0; e.chk_ad = 1'b0; e.widx = int'(a - BASE);
            expq.push_back(e);
        end
        idle(next_at - 4);
    endtask

    task automatic do_read(input logic [31:0] a, input int next_at);
        int   k;
        exp_t e;
        issue(1'b1, a, 32'h0, 2, k);
        if (is_hit(a)) begin
            e.cyc = k + 3 + TURN; e.hz = 1'b0; e.chk_ad = 1'b1; e.widx = -1;
            e.ad  = model[a - BASE][31:16];
            expq.push_back(e);
            e.cyc = k + 4 + TURN;
            e.ad  = model[a - BASE][15:0];
            expq.push_back(e);
        end
        idle(next_at - 2);
    endtask

    // Starts a transaction that is cut short by the next start 'cut' cycles later.
    task automatic do_abort(input bit is_rd, input logic [31:0] a, input int cut);
        int k;
        issue(is_rd, a, 32'($urandom), cut, k);
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < int'(N); i++) begin
            check(name, regs[32*i +: 32], model[i]);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 99) < 85) return BASE + 32'($urandom_range(0, N - 1));
        return 32'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int k;
        for (int i = 0; i < int'(N); i++) model[i] = RSTV;

        // Reset state
        idle(3);
        check("rst_high_z", 32'(high_z), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_ad", 32'(ad_out), 32'd0);
        check_regs("rst_regs");
        rst = 1'b0;
        idle(2);
        mon_en = 1'b1;

        // Directed: write then read back reg 3, then misses
        do_write(BASE + 3, 32'hDEAD_BEEF, 6);
        check_regs("wr3_regs");
        do_read(BASE + 3, 8);
        do_write(BASE + N, 32'h1111_2222, 8);
        do_write(BASE - 1, 32'h3333_4444, 8);
        do_read(BASE + N, 10);
        check_regs("miss_regs");

        // Restart at k+2 of a write drops it; second one completes
        do_abort(1'b0, BASE + 7, 2);
        do_write(BASE + 7, 32'h0123_4567, 6);
        // Start during WR_ACK: ack completes, next read proceeds
        do_write(BASE + 9, 32'h89AB_CDEF, 5);
        do_read(BASE + 9, 8);
        // Read cut during turnaround
        do_abort(1'b1, BASE + 3, 4);
        do_read(BASE + 7, 8);
        check_regs("abort_regs");

        // Random traffic
        for (int t = 0; t < 120; t++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 4)      do_write(rand_addr(), 32'($urandom), 5 + $urandom_range(0, 3));
            else if (kind < 8) do_read(rand_addr(), 7 + $urandom_range(0, 3));
            else               do_abort(kind[0], rand_addr(), 1 + $urandom_range(0, 3));
        end
        idle(10);
        check_regs("rand_regs");

        // Reset asserted while the read's high word is on the bus
        do_write(BASE + 5, 32'hCAFE_F00D, 8);
        mon_en = 1'b0;
        issue(1'b1, BASE + 5, 32'h0, 2, k);
        idle(2 + TURN);
        check("rd_hi_drive", 32'(high_z), 32'd0);
        check("rd_hi_data", 32'(ad_out), 32'h0000_CAFE);
        #1 rst = 1'b1;
        #1;
        check("async_rst_high_z", 32'(high_z), 32'd1);
        check("async_rst_ack", 32'(ack), 32'd0);
        for (int i = 0; i < int'(N); i++) model[i] = RSTV;
        check_regs("async_rst_regs");
        expq.delete();
        idle(2);
        rst = 1'b0;
        idle(2);
        mon_en = 1'b1;
        do_write(BASE + 0, 32'h5555_AAAA, 6);
        do_read(BASE + 0, 8);
        idle(10);

        n_cmp++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL pending_expect: actual %0d required 0", expq.size());
        end
        check_regs("final_regs");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
